bcd_conv_sched: RTL
===================

# bcd_conv_sched

Multi-channel binary-to-BCD conversion scheduler for the OLED display path. It shares one iterative shift-add-3 engine among four 12-bit measurement channels, such as measured frequency, generator frequency, amplitude and duty. It arbitrates among them round-robin, converts one channel in 12 shift cycles, and holds per-channel 4-digit BCD results for the OLED character logic. Conversions start on per-channel request pulses and on an optional periodic refresh tick.

## Interface
- `REFRESH_CYCLES`, default 5_000_000: refresh tick period in clk cycles. 0 disables the refresh tick.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `bin_bus`  in  48  channel k binary value at [12k+11:12k]; unsigned, 0..4095.
- `req`  in  4  per-channel conversion request; one pulse per cycle high.
- `bcd_bus`  out  64  channel k result at [16k+15:16k]: thousands, hundreds, tens, ones (MSB to LSB).
- `valid`  out  4  bit k set once channel k has completed at least one conversion.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse; a result was just written.
- `done_ch`  out  2  channel index written; meaningful only while `done`=1.

## Operation
- **Pending flags `pend[3:0]`:**
  - `pend[k]` is set by `req[k]`=1, or by a refresh tick, which sets all four.
  - `pend[k]` is cleared when channel k is granted.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- **Round-robin pointer `ptr` (2 bits):** after a WRITE of channel c, `ptr` = (c+1) mod 4. Reset value is 0.
- **FSM states:** IDLE, LOAD, SHIFT, WRITE.
  - IDLE: if `pend` is nonzero, grant the first pending channel searching `ptr`, `ptr`+1, … (mod 4). Latch it as `ch`, clear `pend[ch]`, go to LOAD. Otherwise stay in IDLE.
  - LOAD: shift register is 28 bits: [27:12] = 0, [11:0] = `bin_bus` slice `ch`. Set `cnt` = 0, go to SHIFT. `bin_bus` is sampled only here.
  - SHIFT: each cycle, every BCD nibble ≥ 5 gets +3 first, then the whole register shifts left 1. `cnt` increments. After the 12th shift (`cnt`=11), go to WRITE.
  - WRITE: copy [27:12] into channel `ch` result, set `valid[ch]`, register `done`=1 and `done_ch`=`ch`, update `ptr`, go to IDLE.
- **Refresh:** a free-running counter runs 0..`REFRESH_CYCLES`-1. At wrap it generates a one-cycle tick. It is unaffected by FSM state.
- **Arithmetic:** all 12-bit inputs fit in 4 digits (max 4095), so there is no overflow case. Digits are never above 9 after conversion.
- Results for non-converting channels hold their value. A channel's result changes only on its own WRITE.

## Timing
- **Reset:** applies on the clk edge where `rst_n`=0, including mid-conversion. Reset values:
  - `bcd_bus`=0, `valid`=0, `busy`=0, `done`=0, `done_ch`=0.
  - `pend`=0, `ptr`=0, refresh counter 0, state IDLE.
  - An aborted conversion produces no `done`.
- **Latency:** `req[k]` high in cycle 0 while idle with nothing pending gives:
  - cycle 1: IDLE grant.
  - cycle 2: LOAD.
  - cycles 3–14: SHIFT.
  - cycle 15: WRITE.
  - cycle 16: `done`=1 with new `bcd_bus`/`valid`. `done` is high only in this cycle.
- **Service time:** 15 cycles per channel (IDLE + LOAD + 12 SHIFT + WRITE). Back-to-back grants need no extra gap. Four pending channels complete within 60 cycles.
- `busy` is 1 from LOAD through WRITE, and 0 in the IDLE cycle that performs the grant.
- `req[k]` during channel k's own conversion re-sets `pend[k]`, so k is converted again after the others pending ahead of it by round-robin.
- `bin_bus` changes after LOAD do not affect the result in flight.

## Test plan
- **Single request:** `REFRESH_CYCLES`=0, `bin_bus` ch0=4095, pulse `req`=0001 in cycle 0 → `done`=1, `done_ch`=0 in cycle 16 only; `bcd_bus`[15:0]=0x4095; `valid`=0001.
- **Simultaneous requests:** ch0..3 = 0, 9, 10, 1234, `req`=1111 in one cycle → `done_ch` sequence 0,1,2,3 at cycles 16, 31, 46, 61; results 0x0000, 0x0009, 0x0010, 0x1234; `valid`=1111.
- **Round-robin order:** after ch1 completes (`ptr`=2), pulse `req`=0101 → ch2 served before ch0.
- **Sampling and re-request:** ch3=500, `req`[3] pulse; during SHIFT change ch3 to 77 and pulse `req`[3] again → first `done` gives 0x0500, second `done` 15 cycles later gives 0x0077.
- **Reset mid-conversion:** `rst_n`=0 for one cycle during SHIFT → all outputs 0, no `done`; a following `req`=0010 with ch1=42 gives 0x0042 after 16 cycles.
- **Periodic refresh:** `REFRESH_CYCLES`=100, no `req` → exactly 4 `done` pulses (channels in order 0..3) per 100-cycle period; results track `bin_bus`.

Source files
------------

// File: rtl/bcd_conv_sched.sv
// Four-channel binary-to-BCD scheduler: one shared shift-add-3 engine, round-robin
// arbitration over per-channel request/refresh pending flags, per-channel result hold.
module bcd_conv_sched #(
  parameter int unsigned REFRESH_CYCLES = 32'd5_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [47:0] bin_bus,
  input  logic [3:0]  req,
  output logic [63:0] bcd_bus,
  output logic [3:0]  valid,
  output logic        busy,
  output logic        done,
  output logic [1:0]  done_ch
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    WRITE = 2'd3
  } state_t;

  localparam bit          REF_EN   = (REFRESH_CYCLES != 32'd0);
  localparam logic [31:0] REF_LAST = REF_EN ? (REFRESH_CYCLES - 32'd1) : 32'd0;

  state_t      state_r, state_nxt_s;
  logic [3:0]  pend_r, pend_nxt_s, clr_s;
  logic [1:0]  ptr_r, ch_r;
  logic [3:0]  cnt_r;
  logic [27:0] sh_r;
  logic [15:0] bcd_r [4];
  logic [3:0]  valid_r;
  logic        busy_r, done_r;
  logic [1:0]  done_ch_r;
  logic [31:0] ref_cnt_r;
  logic        tick_s;
  logic        grant_vld_s;
  logic [1:0]  grant_ch_s;
  logic [11:0] bin_sel_s;

  // One double-dabble step: correct every BCD nibble >= 5, then shift left.
  function automatic logic [27:0] bcd_step(input logic [27:0] v);
    logic [27:0] t;
    t = v;
    for (int i = 0; i < 4; i++) begin
      t[12 + 4*i +: 4] = (t[12 + 4*i +: 4] >= 4'd5) ? (t[12 + 4*i +: 4] + 4'd3)
                                                    : t[12 + 4*i +: 4];
    end
    return {t[26:0], 1'b0};
  endfunction

  // Refresh tick on the last count of the free-running period.
  always_comb begin
    tick_s = 1'b0;
    if (REF_EN) begin
      tick_s = (ref_cnt_r == REF_LAST);
    end else begin
      tick_s = 1'b0;
    end
  end

  // Free-running refresh counter, independent of the FSM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ref_cnt_r <= 32'd0;
    end else if (!REF_EN || tick_s) begin
      ref_cnt_r <= 32'd0;
    end else begin
      ref_cnt_r <= ref_cnt_r + 32'd1;
    end
  end

  // Round-robin search from ptr; descending loop so the nearest pending channel wins.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_ch_s  = ptr_r;
    for (int i = 3; i >= 0; i--) begin
      if (pend_r[ptr_r + 2'(i)]) begin
        grant_vld_s = 1'b1;
        grant_ch_s  = ptr_r + 2'(i);
      end else begin
        grant_vld_s = grant_vld_s;
        grant_ch_s  = grant_ch_s;
      end
    end
  end

  // Channel slice selected for loading.
  always_comb begin
    bin_sel_s = 12'd0;
    case (ch_r)
      2'd0:    bin_sel_s = bin_bus[11:0];
      2'd1:    bin_sel_s = bin_bus[23:12];
      2'd2:    bin_sel_s = bin_bus[35:24];
      2'd3:    bin_sel_s = bin_bus[47:36];
      default: bin_sel_s = 12'd0;
    endcase
  end

  // Next state and pending-flag update; a set beats a same-cycle clear.
  always_comb begin
    state_nxt_s = state_r;
    clr_s       = 4'd0;
    case (state_r)
      IDLE: begin
        if (grant_vld_s) begin
          state_nxt_s = LOAD;
          clr_s       = 4'b0001 << grant_ch_s;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD:    state_nxt_s = SHIFT;
      SHIFT:   state_nxt_s = (cnt_r == 4'd11) ? WRITE : SHIFT;
      WRITE:   state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
    pend_nxt_s = (pend_r & ~clr_s) | req | {4{tick_s}};
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      pend_r    <= 4'd0;
      ptr_r     <= 2'd0;
      ch_r      <= 2'd0;
      cnt_r     <= 4'd0;
      sh_r      <= 28'd0;
      valid_r   <= 4'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      done_ch_r <= 2'd0;
      for (int k = 0; k < 4; k++) begin
        bcd_r[k] <= 16'd0;
      end
    end else begin
      state_r <= state_nxt_s;
      pend_r  <= pend_nxt_s;
      busy_r  <= (state_nxt_s != IDLE);
      done_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_vld_s) begin
            ch_r <= grant_ch_s;
          end else begin
            ch_r <= ch_r;
          end
        end
        LOAD: begin
          sh_r  <= {16'd0, bin_sel_s};
          cnt_r <= 4'd0;
        end
        SHIFT: begin
          sh_r  <= bcd_step(sh_r);
          cnt_r <= cnt_r + 4'd1;
        end
        WRITE: begin
          bcd_r[ch_r]   <= sh_r[27:12];
          valid_r[ch_r] <= 1'b1;
          done_r        <= 1'b1;
          done_ch_r     <= ch_r;
          ptr_r         <= ch_r + 2'd1;
        end
        default: begin
          ch_r <= ch_r;
        end
      endcase
    end
  end

  assign bcd_bus = {bcd_r[3], bcd_r[2], bcd_r[1], bcd_r[0]};
  assign valid   = valid_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign done_ch = done_ch_r;

endmodule
